// File: rtl/ssm_pkg.sv
// Shared definitions for the SSM group collector: default lane geometry,
// the derived tiles-per-group count, the output FSM state type and a
// ceil-log2 helper usable in constant expressions.
package ssm_pkg;

    localparam int DW_DEF      = 16;
    localparam int N_TILE_DEF  = 16;
    localparam int N_TOTAL_DEF = 128;
    localparam int TPG_DEF     = N_TOTAL_DEF / N_TILE_DEF;

    // Output-side state: either nothing presented or one group presented.
    typedef enum logic {
        OUT_IDLE  = 1'b0,
        OUT_VALID = 1'b1
    } out_state_e;

    // Ceiling log2, never less than 1 so it can size any counter or pointer.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ssm_sync_fifo.sv
// Small synchronous FIFO holding xD scalars. Exposes the head entry and the
// entry behind it so the consumer can present two groups back to back.
// Pointers wrap modulo DEPTH (power of two). Reset is synchronous, active-high.
module ssm_sync_fifo
    import ssm_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          din,
    input  logic                  pop,
    output logic [W-1:0]          dout,
    output logic [W-1:0]          dout_nxt,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign dout     = mem[rd_ptr];
    assign dout_nxt = mem[rd_ptr + AW'(1)];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/ssm_group_collector.sv
// Collects N_TILE-lane hC tiles into N_TOTAL-lane groups and pairs each
// completed group with the next x*D scalar from a side FIFO.
//
// Optional feature: define SSM_COLLECT_DBUF_EN for two ping-pong banks so one
// group can fill while the previous one waits for the adder tree. Without it
// a single bank is used and tile input stalls while that bank is full.
//
// Handshakes: every interface transfers on a cycle where valid and ready are
// both high at the rising edge; valid never waits on ready, and a presented
// group (grp_*) stays stable until it is taken.
module ssm_group_collector
    import ssm_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int N_TILE   = N_TILE_DEF,
    parameter int N_TOTAL  = N_TOTAL_DEF,
    parameter int XD_DEPTH = 4,
    parameter int IDXW     = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tile_valid_i,
    output logic                              tile_ready_o,
    input  logic [N_TILE*DW-1:0]              tile_i,
    input  logic                              xd_valid_i,
    output logic                              xd_ready_o,
    input  logic [DW-1:0]                     xd_i,
    input  logic                              flush_i,
    output logic                              grp_valid_o,
    input  logic                              grp_ready_i,
    output logic [N_TOTAL*DW-1:0]             grp_data_o,
    output logic [DW-1:0]                     grp_xd_o,
    output logic [IDXW-1:0]                   grp_idx_o,
    output logic [clog2(N_TOTAL/N_TILE)-1:0]  tile_cnt_o,
    output out_state_e                        dbg_state
);

    localparam int TPG = N_TOTAL / N_TILE;
    localparam int CW  = clog2(TPG);
    localparam int TW  = N_TILE * DW;
    localparam int GW  = N_TOTAL * DW;
    localparam int XCW = clog2(XD_DEPTH) + 1;

`ifdef SSM_COLLECT_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic            tile_acc;
    logic            tile_last;
    logic            tile_wrap;
    logic            xd_acc;
    logic            hs;
    logic [NB-1:0]   bank_full;
    logic [NB-1:0]   bank_full_d;
    logic [GW-1:0]   bank_mem [NB];
    logic            wr_sel;
    logic            rd_sel;
    logic            nxt_sel;
    logic            nxt_full;
    logic            all_full;
    out_state_e      state;
    out_state_e      state_d;
    logic            load_first;
    logic            load_next;
    logic            pop;
    logic [DW-1:0]   fifo_head;
    logic [DW-1:0]   fifo_nxt;
    logic            fifo_full;
    logic            fifo_empty;
    logic [XCW-1:0]  fifo_count;
    logic            two_xd;

    assign tile_ready_o = !all_full;
    assign xd_ready_o   = !fifo_full;
    assign tile_acc     = tile_valid_i && tile_ready_o;
    assign tile_last    = (tile_cnt_o == CW'(TPG - 1));
    assign tile_wrap    = tile_acc && !flush_i && tile_last;
    assign xd_acc       = xd_valid_i && xd_ready_o;
    assign grp_valid_o  = (state == OUT_VALID);
    assign hs           = grp_valid_o && grp_ready_i;
    assign two_xd       = (fifo_count >= XCW'(2));
    assign dbg_state    = state;

    ssm_sync_fifo #(
        .W     (DW),
        .DEPTH (XD_DEPTH)
    ) u_xd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (xd_acc),
        .din      (xd_i),
        .pop      (pop),
        .dout     (fifo_head),
        .dout_nxt (fifo_nxt),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

`ifdef SSM_COLLECT_DBUF_EN
    // Ping-pong selects: fill side advances on a completed group, read side on a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (tile_wrap) begin
                wr_sel <= ~wr_sel;
            end
            if (hs) begin
                rd_sel <= ~rd_sel;
            end
        end
    end

    assign nxt_sel  = ~rd_sel;
    assign nxt_full = bank_full[nxt_sel];
    assign all_full = &bank_full;
`else
    assign wr_sel   = 1'b0;
    assign rd_sel   = 1'b0;
    assign nxt_sel  = 1'b0;
    assign nxt_full = 1'b0;
    assign all_full = bank_full[0];
`endif

    // Tile slot counter; flush discards the partial group and any same-cycle tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            tile_cnt_o <= '0;
        end else if (flush_i) begin
            tile_cnt_o <= '0;
        end else if (tile_acc) begin
            tile_cnt_o <= tile_last ? '0 : tile_cnt_o + CW'(1);
        end
    end

    // Bank data; a dropped (flushed) tile is never written.
    always_ff @(posedge clk) begin
        if (tile_acc && !flush_i) begin
            for (int s = 0; s < TPG; s++) begin
                if (tile_cnt_o == CW'(s)) begin
                    bank_mem[wr_sel][s*TW +: TW] <= tile_i;
                end
            end
        end
    end

    // Bank occupancy: freeing one bank and completing another can share a cycle.
    always_comb begin
        bank_full_d = bank_full;
        if (hs) begin
            bank_full_d[rd_sel] = 1'b0;
        end
        if (tile_wrap) begin
            bank_full_d[wr_sel] = 1'b1;
        end
    end

    // Bank occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full <= '0;
        end else begin
            bank_full <= bank_full_d;
        end
    end

    // Output FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OUT_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Output FSM next state: present when a full bank and an xD are both held.
    always_comb begin
        state_d = state;
        case (state)
            OUT_IDLE: begin
                if (bank_full[rd_sel] && !fifo_empty) begin
                    state_d = OUT_VALID;
                end
            end
            OUT_VALID: begin
                if (hs && !(nxt_full && two_xd)) begin
                    state_d = OUT_IDLE;
                end
            end
            default: state_d = OUT_IDLE;
        endcase
    end

    // Output FSM strobes: first load from idle, or a back-to-back reload on handshake.
    always_comb begin
        load_first = 1'b0;
        load_next  = 1'b0;
        pop        = 1'b0;
        case (state)
            OUT_IDLE: begin
                load_first = bank_full[rd_sel] && !fifo_empty;
            end
            OUT_VALID: begin
                pop       = hs;
                load_next = hs && nxt_full && two_xd;
            end
            default: begin
                load_first = 1'b0;
            end
        endcase
    end

    // Presented group registers; they only change on a load, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            grp_data_o <= '0;
            grp_xd_o   <= '0;
            grp_idx_o  <= '0;
        end else begin
            if (hs) begin
                grp_idx_o <= grp_idx_o + IDXW'(1);
            end
            if (load_first) begin
                grp_data_o <= bank_mem[rd_sel];
                grp_xd_o   <= fifo_head;
            end else if (load_next) begin
                grp_data_o <= bank_mem[nxt_sel];
                grp_xd_o   <= fifo_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ssm_group_collector.sv
// Directed bench for ssm_group_collector with a group/xD scoreboard.
// Honours SSM_COLLECT_DBUF_EN the same way the design does.
module tb_ssm_group_collector;
  import ssm_pkg::*;

  localparam int DW       = 16;
  localparam int N_TILE   = 16;
  localparam int N_TOTAL  = 128;
  localparam int XD_DEPTH = 4;
  localparam int IDXW     = 8;
  localparam int TPG      = N_TOTAL / N_TILE;
  localparam int TW       = N_TILE * DW;
  localparam int GW       = N_TOTAL * DW;
`ifdef SSM_COLLECT_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              tile_valid_i;
  logic              tile_ready_o;
  logic [TW-1:0]     tile_i;
  logic              xd_valid_i;
  logic              xd_ready_o;
  logic [DW-1:0]     xd_i;
  logic              flush_i;
  logic              grp_valid_o;
  logic              grp_ready_i;
  logic [GW-1:0]     grp_data_o;
  logic [DW-1:0]     grp_xd_o;
  logic [IDXW-1:0]   grp_idx_o;
  logic [2:0]        tile_cnt_o;
  out_state_e        dbg_state;

  logic [GW-1:0]     exp_q[$];
  logic [DW-1:0]     exp_xd_q[$];
  logic [GW-1:0]     e_data;
  logic [DW-1:0]     e_xd;
  logic [IDXW-1:0]   rx_idx;
  logic [GW-1:0]     ramp;
  int                n_asserts = 0;
  int                n_fail = 0;
  int                next_tile = 0;

  ssm_group_collector #(
    .DW       (DW),
    .N_TILE   (N_TILE),
    .N_TOTAL  (N_TOTAL),
    .XD_DEPTH (XD_DEPTH),
    .IDXW     (IDXW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tile_valid_i (tile_valid_i),
    .tile_ready_o (tile_ready_o),
    .tile_i       (tile_i),
    .xd_valid_i   (xd_valid_i),
    .xd_ready_o   (xd_ready_o),
    .xd_i         (xd_i),
    .flush_i      (flush_i),
    .grp_valid_o  (grp_valid_o),
    .grp_ready_i  (grp_ready_i),
    .grp_data_o   (grp_data_o),
    .grp_xd_o     (grp_xd_o),
    .grp_idx_o    (grp_idx_o),
    .tile_cnt_o   (tile_cnt_o),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
    int bad;
    bad = 0;
    for (int l = N_TOTAL - 1; l >= 0; l--) begin
      if (obs[l*DW +: DW] !== exp[l*DW +: DW]) bad = l;
    end
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: lane %0d observed=%0h expected=%0h", tag, bad,
             obs[bad*DW +: DW], exp[bad*DW +: DW]);
    end
  endtask

  function automatic logic [TW-1:0] make_tile(input int id);
    logic [TW-1:0] d;
    for (int l = 0; l < N_TILE; l++) d[l*DW +: DW] = DW'(id * N_TILE + l);
    return d;
  endfunction

  // drivers: inputs change at posedge+1, DUT sampled at negedge
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tile(input logic [TW-1:0] d);
    int guard;
    guard = 0;
    tile_valid_i = 1'b1;
    tile_i = d;
    @(negedge clk);
    while (!tile_ready_o && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!tile_ready_o) check("tile_ready_wait", 64'(tile_ready_o), 64'(1));
    tick();
    tile_valid_i = 1'b0;
  endtask

  task automatic send_xd(input logic [DW-1:0] v);
    int guard;
    guard = 0;
    xd_valid_i = 1'b1;
    xd_i = v;
    @(negedge clk);
    while (!xd_ready_o && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!xd_ready_o) check("xd_ready_wait", 64'(xd_ready_o), 64'(1));
    exp_xd_q.push_back(v);
    tick();
    xd_valid_i = 1'b0;
  endtask

  task automatic send_group();
    logic [GW-1:0] g;
    logic [TW-1:0] d;
    for (int t = 0; t < TPG; t++) begin
      d = make_tile(next_tile);
      next_tile++;
      g[t*TW +: TW] = d;
      send_tile(d);
    end
    exp_q.push_back(g);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      tick();
      guard++;
    end
    check("drain_grp_q", 64'(exp_q.size()), 64'(0));
    check("drain_xd_q", 64'(exp_xd_q.size()), 64'(0));
  endtask

  // scoreboard: compare each group on the cycle it is taken
  always @(negedge clk) begin
    if (rst) begin
      rx_idx = '0;
    end else if (grp_valid_o && grp_ready_i) begin
      check("grp_expected", 64'(exp_q.size() != 0 && exp_xd_q.size() != 0), 64'(1));
      if (exp_q.size() != 0 && exp_xd_q.size() != 0) begin
        e_data = exp_q.pop_front();
        e_xd = exp_xd_q.pop_front();
        check_data("grp_data", grp_data_o, e_data);
        check("grp_xd", 64'(grp_xd_o), 64'(e_xd));
        check("grp_idx", 64'(grp_idx_o), 64'(rx_idx));
      end
      rx_idx = rx_idx + 1'b1;
    end
  end

  initial begin
    tile_valid_i = 1'b0;
    tile_i = '0;
    xd_valid_i = 1'b0;
    xd_i = '0;
    flush_i = 1'b0;
    grp_ready_i = 1'b0;
    do_reset();

    // reset state
    check("rst_tile_ready", 64'(tile_ready_o), 64'(1));
    check("rst_xd_ready", 64'(xd_ready_o), 64'(1));
    check("rst_grp_valid", 64'(grp_valid_o), 64'(0));
    check_data("rst_grp_data", grp_data_o, '0);
    check("rst_grp_xd", 64'(grp_xd_o), 64'(0));
    check("rst_grp_idx", 64'(grp_idx_o), 64'(0));
    check("rst_tile_cnt", 64'(tile_cnt_o), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(OUT_IDLE));

    // first group: xD ahead of tiles, lane n carries n
    send_xd(16'h3C00);
    send_group();
    check("g0_valid_at_accept", 64'(grp_valid_o), 64'(0));
    tick();
    check("g0_valid_plus1", 64'(grp_valid_o), 64'(1));
    for (int n = 0; n < N_TOTAL; n++) ramp[n*DW +: DW] = DW'(n);
    check_data("g0_lane_ramp", grp_data_o, ramp);
    check("g0_xd", 64'(grp_xd_o), 64'(16'h3C00));
    check("g0_idx", 64'(grp_idx_o), 64'(0));
    check("g0_tile_cnt", 64'(tile_cnt_o), 64'(0));
    check("g0_tile_ready", 64'(tile_ready_o), 64'(DBUF));
    repeat (3) tick();
    check_data("g0_hold_data", grp_data_o, ramp);
    check("g0_hold_xd", 64'(grp_xd_o), 64'(16'h3C00));
    check("g0_hold_valid", 64'(grp_valid_o), 64'(1));
    grp_ready_i = 1'b1;
    wait_drain();

    // group completes before its xD; xD arrives later
    send_group();
    repeat (5) begin
      tick();
      check("late_xd_wait_valid", 64'(grp_valid_o), 64'(0));
    end
    send_xd(16'h4000);
    check("late_xd_valid_at_accept", 64'(grp_valid_o), 64'(0));
    tick();
    check("late_xd_valid_plus1", 64'(grp_valid_o), 64'(1));
    wait_drain();

    // flush after 3 tiles, with a 4th tile presented in the flush cycle
    for (int k = 0; k < 3; k++) send_tile(make_tile(4000 + k));
    check("flush_pre_cnt", 64'(tile_cnt_o), 64'(3));
    flush_i = 1'b1;
    tile_valid_i = 1'b1;
    tile_i = make_tile(4003);
    tick();
    flush_i = 1'b0;
    tile_valid_i = 1'b0;
    check("flush_cnt", 64'(tile_cnt_o), 64'(0));
    send_xd(16'h4200);
    send_group();
    wait_drain();

    // stall: stream groups with grp_ready low until tile input backs up
    grp_ready_i = 1'b0;
    send_xd(16'h3000);
    send_xd(16'h3100);
    send_xd(16'h3200);
    send_group();
`ifdef SSM_COLLECT_DBUF_EN
    send_group();
`endif
    check("stall_tile_ready_low", 64'(tile_ready_o), 64'(0));
    repeat (3) tick();
    check("stall_tile_ready_hold", 64'(tile_ready_o), 64'(0));
    check("stall_grp_valid", 64'(grp_valid_o), 64'(1));
    check("stall_xd_ready", 64'(xd_ready_o), 64'(1));
    grp_ready_i = 1'b1;
    tick();
    check("release_back_to_back", 64'(grp_valid_o), 64'(DBUF));
    check("release_tile_ready", 64'(tile_ready_o), 64'(1));
    send_group();
`ifndef SSM_COLLECT_DBUF_EN
    send_group();
`endif
    wait_drain();

    // reset with a presented group, a spare xD and (double-buffered) a partial group
    grp_ready_i = 1'b0;
    send_xd(16'h4400);
    send_xd(16'h4500);
    send_group();
    tick();
    check("pre_rst_valid", 64'(grp_valid_o), 64'(1));
`ifdef SSM_COLLECT_DBUF_EN
    for (int k = 0; k < 3; k++) send_tile(make_tile(4100 + k));
    check("pre_rst_cnt", 64'(tile_cnt_o), 64'(3));
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_xd_q.delete();
    check("mid_rst_tile_ready", 64'(tile_ready_o), 64'(1));
    check("mid_rst_xd_ready", 64'(xd_ready_o), 64'(1));
    check("mid_rst_grp_valid", 64'(grp_valid_o), 64'(0));
    check_data("mid_rst_grp_data", grp_data_o, '0);
    check("mid_rst_grp_xd", 64'(grp_xd_o), 64'(0));
    check("mid_rst_grp_idx", 64'(grp_idx_o), 64'(0));
    check("mid_rst_tile_cnt", 64'(tile_cnt_o), 64'(0));
    grp_ready_i = 1'b1;
    send_group();
    repeat (3) begin
      tick();
      check("post_rst_no_stale_xd", 64'(grp_valid_o), 64'(0));
    end
    send_xd(16'h4600);
    wait_drain();

    // 256 more groups: index wraps 255 -> 0
    for (int g = 0; g < 256; g++) begin
      send_xd(DW'(16'h1000 + g));
      send_group();
    end
    wait_drain();
    check("idx_after_wrap", 64'(grp_idx_o), 64'(rx_idx));
    check("idx_wrap_value", 64'(grp_idx_o), 64'(257 % 256));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
